// File: rtl/ysyx_25030085_wb_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_25030085_wb_arbiter
//
// Sole owner of the register-file write port. Arbitrates write-back requests
// from EXU (ALU / PC+4 / immediate results) and LSU (load data), registers the
// winner onto the regfile write port, and keeps a pending-load scoreboard so
// that decode stalls on RAW/WAW hazards against outstanding loads.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   : adds fwd_rs1_hit / fwd_rs2_hit / fwd_data, which forward the
//               registered write-back to decode. The in-flight write then no
//               longer stalls decode.
//   undefined : no fwd_* ports. Decode also stalls on a source or destination
//               that matches the in-flight regfile write.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset (0 = reset)
//   exu_valid/ready/rd/wdata EXU write-back request (valid/ready handshake)
//   lsu_valid/ready/rd/wdata LSU load-data write-back request
//   iss_valid/ready/rd       load issue from IDU. Marks rd as pending.
//   id_rs1/id_rs2/id_rd      registers of the instruction in decode
//   id_stall                 decode must hold (hazard)
//   fwd_rs1_hit/fwd_rs2_hit  (WB_BYPASS_EN only) in-flight write matches rsX
//   fwd_data                 (WB_BYPASS_EN only) forwarded write data
//   rf_we/rf_waddr/rf_wdata  registered regfile write port
// ----------------------------------------------------------------------------
module ysyx_25030085_wb_arbiter #(
   parameter  int XLEN = 32,
   parameter  int NREG = 32,
   localparam int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,

   input  logic            exu_valid,
   output logic            exu_ready,
   input  logic [AW-1:0]   exu_rd,
   input  logic [XLEN-1:0] exu_wdata,

   input  logic            lsu_valid,
   output logic            lsu_ready,
   input  logic [AW-1:0]   lsu_rd,
   input  logic [XLEN-1:0] lsu_wdata,

   input  logic            iss_valid,
   output logic            iss_ready,
   input  logic [AW-1:0]   iss_rd,

   input  logic [AW-1:0]   id_rs1,
   input  logic [AW-1:0]   id_rs2,
   input  logic [AW-1:0]   id_rd,
   output logic            id_stall,
`ifdef WB_BYPASS_EN
   output logic            fwd_rs1_hit,
   output logic            fwd_rs2_hit,
   output logic [XLEN-1:0] fwd_data,
`endif

   output logic            rf_we,
   output logic [AW-1:0]   rf_waddr,
   output logic [XLEN-1:0] rf_wdata
);

   // Bit r set = a load to xr is outstanding. Bit 0 is never set.
   logic [NREG-1:0] pending;
   logic [NREG-1:0] pending_nxt;
   logic            rr_ptr;      // 0: EXU wins the next contention, 1: LSU wins

   logic            exu_elig;    // EXU valid and not blocked by the WAW guard
   logic            contend;     // both requesters could be granted this cycle
   logic            grant_exu;
   logic            grant_lsu;
   logic            iss_fire;
   logic [AW-1:0]   wb_rd;
   logic [XLEN-1:0] wb_data;

   // ---------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: combinational blocks use blocking '=' and give every target a
      // value on every path, so no latch is inferred.
      exu_elig  = exu_valid & ~pending[exu_rd];
      contend   = exu_elig & lsu_valid;
      grant_exu = exu_elig & (~lsu_valid | ~rr_ptr);
      grant_lsu = lsu_valid & (~exu_elig | rr_ptr);
      wb_rd     = grant_lsu ? lsu_rd    : exu_rd;
      wb_data   = grant_lsu ? lsu_wdata : exu_wdata;
   end

   assign exu_ready = grant_exu;
   assign lsu_ready = grant_lsu;

   // A new load to rd is accepted once the previous one to rd is retiring.
   assign iss_ready = ~pending[iss_rd] | (grant_lsu & (lsu_rd == iss_rd));
   assign iss_fire  = iss_valid & iss_ready & (iss_rd != '0);

   // Set is applied after clear: a load issued in the same cycle that an
   // older load to the same rd retires stays outstanding.
   always_comb begin
      pending_nxt = pending;
      if (grant_lsu) pending_nxt[lsu_rd] = 1'b0;
      if (iss_fire)  pending_nxt[iss_rd] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   // ---------------------------------------------------------------------
   // State: scoreboard, round-robin pointer, regfile write register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the scoreboard is a small flop vector, not a RAM, and it must
         // be reset. A stale pending bit would stall decode indefinitely.
         pending  <= '0;
         rr_ptr   <= 1'b0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking '<=' so that every flop
         // samples the pre-edge values, independent of statement order.
         pending <= pending_nxt;
         // Only a true contention moves the pointer, and it moves to the loser.
         if (contend) rr_ptr <= ~rr_ptr;
         rf_we <= 1'b0;
         if (grant_exu | grant_lsu) begin
            rf_we    <= (wb_rd != '0);   // x0 completes the handshake but never writes
            rf_waddr <= wb_rd;
            rf_wdata <= wb_data;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Decode hazard detection / forwarding
   // rf_we is only ever set for a nonzero address, so a match implies rsX != 0.
   // ---------------------------------------------------------------------
   logic rs1_wb;
   logic rs2_wb;
   assign rs1_wb = rf_we & (rf_waddr == id_rs1);
   assign rs2_wb = rf_we & (rf_waddr == id_rs2);

`ifdef WB_BYPASS_EN
   assign id_stall    = pending[id_rs1] | pending[id_rs2] | pending[id_rd];
   assign fwd_rs1_hit = rs1_wb & (id_rs1 != '0);
   assign fwd_rs2_hit = rs2_wb & (id_rs2 != '0);
   assign fwd_data    = rf_wdata;
`else
   logic rd_wb;
   assign rd_wb    = rf_we & (rf_waddr == id_rd);
   assign id_stall = pending[id_rs1] | pending[id_rs2] | pending[id_rd]
                   | rs1_wb | rs2_wb | rd_wb;
`endif

`ifndef SYNTHESIS
   // An LSU write to a register with no outstanding load is legal.
   // It nearly always indicates a pipeline bug, so simulation flags it.
   lsu_rd_not_pending: assert property (@(posedge clk) disable iff (!rst)
      (lsu_valid && lsu_ready) |-> pending[lsu_rd]);
`endif

endmodule

// File: tb/tb_ysyx_25030085_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ysyx_25030085_wb_arbiter
//
// Self-checking bench for ysyx_25030085_wb_arbiter. The directed scenarios
// cover reset, EXU-only, contention, the scoreboard, x0 with a set/clear race,
// the bypass case and a mid-operation reset. They are followed by randomized
// traffic. Every cycle is compared against a behavioural model that holds the
// set of outstanding loads, a "who wins the next tie" flag and the expected
// in-flight write.
// ----------------------------------------------------------------------------
module tb_ysyx_25030085_wb_arbiter;
   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic            exu_valid, exu_ready;
   logic [AW-1:0]   exu_rd;
   logic [XLEN-1:0] exu_wdata;
   logic            lsu_valid, lsu_ready;
   logic [AW-1:0]   lsu_rd;
   logic [XLEN-1:0] lsu_wdata;
   logic            iss_valid, iss_ready;
   logic [AW-1:0]   iss_rd;
   logic [AW-1:0]   id_rs1, id_rs2, id_rd;
   logic            id_stall;
`ifdef WB_BYPASS_EN
   logic            fwd_rs1_hit, fwd_rs2_hit;
   logic [XLEN-1:0] fwd_data;
`endif
   logic            rf_we;
   logic [AW-1:0]   rf_waddr;
   logic [XLEN-1:0] rf_wdata;

   always #5 clk = ~clk;

   ysyx_25030085_wb_arbiter #(.XLEN(XLEN), .NREG(NREG)) dut (
      .clk        (clk),
      .rst        (rst),
      .exu_valid  (exu_valid),
      .exu_ready  (exu_ready),
      .exu_rd     (exu_rd),
      .exu_wdata  (exu_wdata),
      .lsu_valid  (lsu_valid),
      .lsu_ready  (lsu_ready),
      .lsu_rd     (lsu_rd),
      .lsu_wdata  (lsu_wdata),
      .iss_valid  (iss_valid),
      .iss_ready  (iss_ready),
      .iss_rd     (iss_rd),
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_rd      (id_rd),
      .id_stall   (id_stall),
`ifdef WB_BYPASS_EN
      .fwd_rs1_hit(fwd_rs1_hit),
      .fwd_rs2_hit(fwd_rs2_hit),
      .fwd_data   (fwd_data),
`endif
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------
   bit              m_pend [NREG];   // outstanding loads per register
   bit              m_lsu_first;     // LSU wins the next tie
   bit              m_we;            // expected regfile write currently on the port
   logic [AW-1:0]   m_waddr;
   logic [XLEN-1:0] m_wdata;

   bit e_exu_ready, e_lsu_ready, e_iss_ready, e_stall;
`ifdef WB_BYPASS_EN
   bit e_fwd1, e_fwd2;
`endif
   logic obs_exu_ready, obs_lsu_ready, obs_iss_ready, obs_stall;
   int   cand[$];

   task automatic model_reset();
      foreach (m_pend[r]) m_pend[r] = 1'b0;
      m_lsu_first = 1'b0;
      m_we        = 1'b0;
      m_waddr     = '0;
      m_wdata     = '0;
      e_exu_ready = 1'b0;
      e_lsu_ready = 1'b0;
   endtask

   // Expected handshake and hazard outputs for the current inputs.
   task automatic model_eval();
      bit            exu_ok;
      bit            stall;
      logic [AW-1:0] srcs [3];
      exu_ok = exu_valid && !m_pend[exu_rd];
      if (exu_ok && lsu_valid) begin
         e_exu_ready = !m_lsu_first;
         e_lsu_ready = m_lsu_first;
      end else begin
         e_exu_ready = exu_ok;
         e_lsu_ready = lsu_valid;
      end
      e_iss_ready = !m_pend[iss_rd] || (e_lsu_ready && lsu_rd == iss_rd);
      srcs[0] = id_rs1;
      srcs[1] = id_rs2;
      srcs[2] = id_rd;
      stall = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (srcs[i] != 0) begin
            if (m_pend[srcs[i]]) stall = 1'b1;
`ifndef WB_BYPASS_EN
            if (m_we && m_waddr == srcs[i]) stall = 1'b1;
`endif
         end
      end
      e_stall = stall;
`ifdef WB_BYPASS_EN
      e_fwd1 = m_we && id_rs1 != 0 && m_waddr == id_rs1;
      e_fwd2 = m_we && id_rs2 != 0 && m_waddr == id_rs2;
`endif
   endtask

   // Advance the model across one clock edge.
   task automatic model_commit();
      bit exu_ok;
      exu_ok = exu_valid && !m_pend[exu_rd];
      if (exu_ok && lsu_valid) m_lsu_first = !m_lsu_first;
      if (e_lsu_ready) m_pend[lsu_rd] = 1'b0;
      if (iss_valid && e_iss_ready && iss_rd != 0) m_pend[iss_rd] = 1'b1;
      m_we = 1'b0;
      if (e_exu_ready) begin
         m_we = (exu_rd != 0);
         if (m_we) begin m_waddr = exu_rd; m_wdata = exu_wdata; end
      end else if (e_lsu_ready) begin
         m_we = (lsu_rd != 0);
         if (m_we) begin m_waddr = lsu_rd; m_wdata = lsu_wdata; end
      end
   endtask

   // One clock cycle: check the combinational outputs, clock, then check the
   // registered write port. Inputs are set by the caller shortly after posedge.
   task automatic cycle();
      #1;
      model_eval();
      obs_exu_ready = exu_ready;
      obs_lsu_ready = lsu_ready;
      obs_iss_ready = iss_ready;
      obs_stall     = id_stall;
      check("exu_ready", exu_ready, e_exu_ready);
      check("lsu_ready", lsu_ready, e_lsu_ready);
      check("iss_ready", iss_ready, e_iss_ready);
      check("id_stall",  id_stall,  e_stall);
`ifdef WB_BYPASS_EN
      check("fwd_rs1_hit", fwd_rs1_hit, e_fwd1);
      check("fwd_rs2_hit", fwd_rs2_hit, e_fwd2);
      if (e_fwd1 || e_fwd2) check("fwd_data", fwd_data, m_wdata);
`endif
      model_commit();
      @(posedge clk);
      #1;
      check("rf_we", rf_we, m_we);
      if (m_we) begin
         check("rf_waddr", rf_waddr, m_waddr);
         check("rf_wdata", rf_wdata, m_wdata);
      end
   endtask

   task automatic idle();
      exu_valid = 0; exu_rd = '0; exu_wdata = '0;
      lsu_valid = 0; lsu_rd = '0; lsu_wdata = '0;
      iss_valid = 0; iss_rd = '0;
      id_rs1 = '0; id_rs2 = '0; id_rd = '0;
   endtask

   function automatic logic [AW-1:0] rnd_reg();
      if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG-1));
      return AW'($urandom_range(0, 7));
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] grants;

      // ---- 1: reset while both requesters are valid ----
      idle();
      rst = 1'b1;
      #1 rst = 1'b0;
      exu_valid = 1; exu_rd = 5'd5; exu_wdata = 32'hFFFF_FFFF;
      lsu_valid = 1; lsu_rd = 5'd2; lsu_wdata = 32'hAAAA_AAAA;
      repeat (2) @(posedge clk);
      #1;
      check("rst.rf_we", rf_we, 0);
      check("rst.rf_waddr", rf_waddr, 0);
      check("rst.rf_wdata", rf_wdata, 0);
      exu_valid = 0; lsu_valid = 0;
      for (int r = 1; r < NREG; r++) begin
         id_rs1 = AW'(r);
         #1;
         check("rst.pending_clear", id_stall, 0);
      end
      idle();
      model_reset();
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      cycle();
      check("rst.no_write_after_release", rf_we, 0);

      // ---- 2: EXU only ----
      exu_valid = 1; exu_rd = 5'd5; exu_wdata = 32'h1234;
      cycle();
      check("t2.exu_ready", obs_exu_ready, 1);
      check("t2.rf_we", rf_we, 1);
      check("t2.rf_waddr", rf_waddr, 5);
      check("t2.rf_wdata", rf_wdata, 32'h1234);
      idle();
      cycle();
      check("t2.we_one_cycle", rf_we, 0);

      // ---- 3: contention alternates; a re-issue of x2 races its retirement ----
      iss_valid = 1; iss_rd = 5'd2;
      cycle();
      idle();
      exu_valid = 1; exu_rd = 5'd1; exu_wdata = 32'h11;
      lsu_valid = 1; lsu_rd = 5'd2; lsu_wdata = 32'h22;
      grants = '0;
      for (int i = 0; i < 4; i++) begin
         iss_valid = (i == 1); iss_rd = 5'd2;
         cycle();
         grants[i] = obs_exu_ready;
      end
      check("t3.alternate", grants, 4'b0101);
      idle();
      cycle();

      // ---- 4: scoreboard ----
      iss_valid = 1; iss_rd = 5'd7;
      cycle();
      check("t4.issue_accepted", obs_iss_ready, 1);
      idle();
      id_rs1 = 5'd7;
      cycle();
      check("t4.stall_on_pending", obs_stall, 1);
      exu_valid = 1; exu_rd = 5'd7; exu_wdata = 32'h77;
      lsu_valid = 1; lsu_rd = 5'd7; lsu_wdata = 32'hCAFE;
      cycle();
      check("t4.exu_waw_blocked", obs_exu_ready, 0);
      check("t4.lsu_granted", obs_lsu_ready, 1);
      check("t4.rf_waddr", rf_waddr, 7);
      check("t4.rf_wdata", rf_wdata, 32'hCAFE);
      lsu_valid = 0;
      cycle();
      check("t4.exu_after_clear", obs_exu_ready, 1);
      exu_valid = 0;
      cycle();
      cycle();
      check("t4.stall_dropped", obs_stall, 0);

      // ---- 5: x0 write and set/clear race ----
      idle();
      exu_valid = 1; exu_rd = 5'd0; exu_wdata = 32'hDEAD;
      cycle();
      check("t5.x0_handshake", obs_exu_ready, 1);
      check("t5.x0_no_write", rf_we, 0);
      idle();
      iss_valid = 1; iss_rd = 5'd3;
      cycle();
      idle();
      lsu_valid = 1; lsu_rd = 5'd3; lsu_wdata = 32'h33;
      iss_valid = 1; iss_rd = 5'd3;
      cycle();
      check("t5.race_iss_ready", obs_iss_ready, 1);
      idle();
      cycle();
      id_rs1 = 5'd3; iss_rd = 5'd3;
      cycle();
      check("t5.x3_still_pending", obs_stall, 1);
      check("t5.second_issue_blocked", obs_iss_ready, 0);
      idle();
      lsu_valid = 1; lsu_rd = 5'd3; lsu_wdata = 32'h34;
      cycle();
      idle();
      cycle();

      // ---- 6: in-flight write to x9 seen by decode ----
      exu_valid = 1; exu_rd = 5'd9; exu_wdata = 32'h55;
      cycle();
      idle();
      id_rs2 = 5'd9;
      cycle();
`ifdef WB_BYPASS_EN
      check("t6.fwd_no_stall", obs_stall, 0);
`else
      check("t6.inflight_stall", obs_stall, 1);
`endif
      cycle();
      check("t6.visible_no_stall", obs_stall, 0);

      // ---- 7: reset mid-operation ----
      idle();
      iss_valid = 1; iss_rd = 5'd4;
      cycle();
      idle();
      exu_valid = 1; exu_rd = 5'd6; exu_wdata = 32'h66;
      cycle();
      idle();
      id_rs1 = 5'd4;
      #2 rst = 1'b0;
      #1;
      check("t7.we_dropped", rf_we, 0);
      check("t7.pending_forgotten", id_stall, 0);
      model_reset();
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      cycle();

      // ---- randomized traffic ----
      idle();
      for (int n = 0; n < 3000; n++) begin
         // A requester that was not accepted keeps its request unchanged.
         if (!(exu_valid && !e_exu_ready)) begin
            exu_valid = ($urandom_range(0, 2) != 0);
            exu_rd    = rnd_reg();
            exu_wdata = $urandom;
         end
         if (!(lsu_valid && !e_lsu_ready)) begin
            cand.delete();
            for (int r = 1; r < NREG; r++) if (m_pend[r]) cand.push_back(r);
            if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
               lsu_valid = 1;
               lsu_rd    = AW'(cand[$urandom_range(0, cand.size() - 1)]);
               lsu_wdata = $urandom;
            end else begin
               lsu_valid = 0;
            end
         end
         iss_valid = ($urandom_range(0, 2) == 0);
         iss_rd    = rnd_reg();
         id_rs1    = rnd_reg();
         id_rs2    = rnd_reg();
         id_rd     = rnd_reg();
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
